// File: rtl/hazard_scoreboard_if.sv
// Handshake/control bundle between the ID-stage pipeline and hazard_scoreboard.
// The pipeline side uses the master modport and the scoreboard uses the slave modport.
interface hazard_scoreboard_if #(
   parameter int RW   = 5,
   parameter int NSRC = 2
);
   // ID-stage instruction description
   logic              id_valid;
   logic [NSRC*RW-1:0] id_rs;
   logic [NSRC-1:0]   id_rs_used;
   logic [RW-1:0]     id_rd;
   logic              id_regwrite;
   logic              id_is_load;
   // pipeline events
   logic              ex_flush;
   logic              ihit;
   logic              dmem_req;
   logic              dhit;
   // latch controls back to the datapath
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_write;
   logic              id_ex_flush;
   logic              ex_mem_write;
   logic              stall;
   logic              hazard_detected;
   logic [1:0]        stall_cause;

   modport master (
      output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load,
      output ex_flush, ihit, dmem_req, dhit,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
      input  ex_mem_write, stall, hazard_detected, stall_cause
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load,
      input  ex_flush, ihit, dmem_req, dhit,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
      output ex_mem_write, stall, hazard_detected, stall_cause
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register distance scoreboard resolving memory freeze, branch flush, load-use and fetch-miss hazards.
// Define HAZARD_FWD_EN for the forwarding datapath (only loads are tracked, to LOAD_USE_DIST).
module hazard_scoreboard #(
   parameter int NREGS         = 32,
   parameter int NSRC          = 2,
   parameter int LOAD_USE_DIST = 1,
   parameter int NOFWD_DIST    = 3
) (
   input logic            CLK,
   input logic            nRST,
   hazard_scoreboard_if.slave hz
);
   localparam int RW   = $clog2(NREGS);
   localparam int MAXD = (LOAD_USE_DIST > NOFWD_DIST) ? LOAD_USE_DIST : NOFWD_DIST;
   localparam int CW   = (MAXD < 1) ? 1 : $clog2(MAXD + 1);

   logic [CW-1:0] cnt_q [NREGS];
   logic [CW-1:0] cnt_d [NREGS];

   logic          mem_wait;
   logic          data_haz;
   logic          issue;
   logic          set_en;
   logic [CW-1:0] set_dist;
   logic [RW-1:0] src;

   logic          pc_write_c;
   logic          if_id_write_c;
   logic          if_id_flush_c;
   logic          id_ex_write_c;
   logic          id_ex_flush_c;
   logic          ex_mem_write_c;
   logic          stall_c;
   logic          hazard_c;
   logic [1:0]    cause_c;

   assign mem_wait = hz.dmem_req & ~hz.dhit;

   // Operand check uses the pre-issue counts, so an instruction never waits on its own write.
   always_comb begin
      data_haz = 1'b0;
      src      = '0;
      for (int k = 0; k < NSRC; k++) begin
         src = hz.id_rs[k*RW +: RW];
         if (hz.id_rs_used[k] && (src != '0) && (cnt_q[src] != '0)) begin
            data_haz = 1'b1;
         end
      end
      data_haz = data_haz & hz.id_valid;
   end

   assign issue = hz.id_valid & ~mem_wait & ~hz.ex_flush & ~data_haz;

`ifdef HAZARD_FWD_EN
   assign set_en   = issue & hz.id_regwrite & hz.id_is_load & (hz.id_rd != '0);
   assign set_dist = CW'(LOAD_USE_DIST);
`else
   logic unused_is_load;
   assign unused_is_load = hz.id_is_load;
   assign set_en   = issue & hz.id_regwrite & (hz.id_rd != '0);
   assign set_dist = CW'(NOFWD_DIST);
`endif

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!mem_wait && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
         end
         if (set_en && (hz.id_rd == RW'(r))) begin
            cnt_d[r] = set_dist;
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   // Fixed priority: memory freeze, then branch flush, then data hazard, then fetch miss.
   always_comb begin
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      if_id_flush_c  = 1'b0;
      id_ex_write_c  = 1'b1;
      id_ex_flush_c  = 1'b0;
      ex_mem_write_c = 1'b1;
      stall_c        = 1'b0;
      hazard_c       = 1'b0;
      cause_c        = 2'd0;
      if (mem_wait) begin
         pc_write_c     = 1'b0;
         if_id_write_c  = 1'b0;
         id_ex_write_c  = 1'b0;
         ex_mem_write_c = 1'b0;
         stall_c        = 1'b1;
         cause_c        = 2'd1;
      end else if (hz.ex_flush) begin
         if_id_flush_c  = 1'b1;
         id_ex_flush_c  = 1'b1;
      end else if (data_haz) begin
         // IF/ID holds the dependent instruction even when the fetch also missed.
         pc_write_c     = 1'b0;
         if_id_write_c  = 1'b0;
         id_ex_flush_c  = 1'b1;
         stall_c        = 1'b1;
         hazard_c       = 1'b1;
         cause_c        = 2'd2;
      end else if (!hz.ihit) begin
         pc_write_c     = 1'b0;
         if_id_flush_c  = 1'b1;
         stall_c        = 1'b1;
         cause_c        = 2'd3;
      end
   end

   assign hz.pc_write        = pc_write_c;
   assign hz.if_id_write     = if_id_write_c;
   assign hz.if_id_flush     = if_id_flush_c;
   assign hz.id_ex_write     = id_ex_write_c;
   assign hz.id_ex_flush     = id_ex_flush_c;
   assign hz.ex_mem_write    = ex_mem_write_c;
   assign hz.stall           = stall_c;
   assign hz.hazard_detected = hazard_c;
   assign hz.stall_cause     = cause_c;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expected distances follow the HAZARD_FWD_EN build choice.
module tb_hazard_scoreboard;
   // output vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
   // ex_mem_write, stall, hazard_detected, stall_cause[1:0]
   localparam logic [9:0] NORM = 10'b1_1_0_1_0_1_0_0_00;
   localparam logic [9:0] MEMW = 10'b0_0_0_0_0_0_1_0_01;
   localparam logic [9:0] FLSH = 10'b1_1_1_1_1_1_0_0_00;
   localparam logic [9:0] HAZ  = 10'b0_0_0_1_1_1_1_1_10;
   localparam logic [9:0] IMIS = 10'b0_1_1_1_0_1_1_0_11;
   localparam logic [9:0] NOHZ = 10'b1111111011;
`ifdef HAZARD_FWD_EN
   localparam int LD  = 1;
   localparam int ALU = 0;
`else
   localparam int LD  = 3;
   localparam int ALU = 3;
`endif

   logic CLK;
   logic nRST;
   int   checks;
   int   failures;
   logic [9:0] out;

   hazard_scoreboard_if #(.RW(5), .NSRC(2)) hz ();

   hazard_scoreboard dut (
      .CLK  (CLK),
      .nRST (nRST),
      .hz   (hz)
   );

   assign out = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write, hz.id_ex_flush,
                 hz.ex_mem_write, hz.stall, hz.hazard_detected, hz.stall_cause};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic ins(input logic v, input logic [4:0] r1, input logic [4:0] r0,
                      input logic [1:0] used, input logic [4:0] rd, input logic regw,
                      input logic load);
      hz.id_valid    = v;
      hz.id_rs       = {r1, r0};
      hz.id_rs_used  = used;
      hz.id_rd       = rd;
      hz.id_regwrite = regw;
      hz.id_is_load  = load;
   endtask

   task automatic ctl(input logic fl, input logic ih, input logic dreq, input logic dh);
      hz.ex_flush = fl;
      hz.ihit     = ih;
      hz.dmem_req = dreq;
      hz.dhit     = dh;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         ins(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
         ctl(1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset;
      ins(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      ctl(1'b0, 1'b1, 1'b0, 1'b0);
      nRST = 1'b0;
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", out, NORM);
      end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_load_use;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL lu_issue got=%b exp=%b", out, NORM);
      end
      for (int i = 0; i < LD; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
         #1;
         checks++;
         if (out !== HAZ) begin
            failures++;
            $display("FAIL lu_stall%0d got=%b exp=%b", i, out, HAZ);
         end
      end
      @(negedge CLK);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL lu_release got=%b exp=%b", out, NORM);
      end
      idle(4);
      // only the second operand depends on the load
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd9, 1'b1, 1'b1);
      @(negedge CLK);
      ins(1'b1, 5'd9, 5'd2, 2'b10, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== HAZ) begin
         failures++;
         $display("FAIL lu_rs1 got=%b exp=%b", out, HAZ);
      end
      idle(4);
   endtask

   task automatic test_mem_wait;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
         ctl(1'b0, 1'b1, 1'b1, 1'b0);
         #1;
         checks++;
         if ((out & NOHZ) !== MEMW) begin
            failures++;
            $display("FAIL mw_freeze%0d got=%b exp=%b", i, out, MEMW);
         end
      end
      for (int i = 0; i < LD; i++) begin
         @(negedge CLK);
         ctl(1'b0, 1'b1, 1'b0, 1'b0);
         #1;
         checks++;
         if (out !== HAZ) begin
            failures++;
            $display("FAIL mw_stall%0d got=%b exp=%b", i, out, HAZ);
         end
      end
      @(negedge CLK);
      ctl(1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL mw_dhit got=%b exp=%b", out, NORM);
      end
      idle(4);
   endtask

   task automatic test_flush;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1);
      @(negedge CLK);
      ins(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b1);
      ctl(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== FLSH) begin
         failures++;
         $display("FAIL fl_flush got=%b exp=%b", out, FLSH);
      end
      @(negedge CLK);
      ctl(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if ((out & NOHZ) !== MEMW) begin
         failures++;
         $display("FAIL fl_under_mw got=%b exp=%b", out, MEMW);
      end
      // the flushed instruction must not have claimed r6
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd6, 2'b01, 5'd0, 1'b0, 1'b0);
      ctl(1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL fl_no_set got=%b exp=%b", out, NORM);
      end
      idle(4);
   endtask

   task automatic test_fetch_miss;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
         ctl(1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         checks++;
         if (out !== IMIS) begin
            failures++;
            $display("FAIL fm_miss%0d got=%b exp=%b", i, out, IMIS);
         end
      end
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1);
      ctl(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LD; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd5, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
         ctl(1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         checks++;
         if (out !== HAZ) begin
            failures++;
            $display("FAIL fm_haz%0d got=%b exp=%b", i, out, HAZ);
         end
      end
      @(negedge CLK);
      #1;
      checks++;
      if (out !== IMIS) begin
         failures++;
         $display("FAIL fm_after got=%b exp=%b", out, IMIS);
      end
      idle(4);
   endtask

   task automatic test_unused_operand;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd5, 1'b1, 1'b1);
      @(negedge CLK);
      ins(1'b1, 5'd5, 5'd5, 2'b00, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL uo_unused got=%b exp=%b", out, NORM);
      end
      idle(4);
   endtask

   task automatic test_self_dep;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd5, 2'b01, 5'd5, 1'b1, 1'b1);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL sd_self got=%b exp=%b", out, NORM);
      end
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== HAZ) begin
         failures++;
         $display("FAIL sd_next got=%b exp=%b", out, HAZ);
      end
      idle(4);
   endtask

   task automatic test_back_to_back;
      int stalls;
      // ALU write: tracked only without forwarding
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd3, 1'b1, 1'b0);
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd0, 5'd3, 2'b01, 5'd4, 1'b1, 1'b0);
         #1;
         if (out === HAZ) stalls++;
         else break;
      end
      checks++;
      if (stalls !== ALU) begin
         failures++;
         $display("FAIL bb_alu_stalls got=%0d exp=%0d", stalls, ALU);
      end
      idle(4);
      // rewrite of r3 while still pending must restart its distance
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd3, 1'b1, 1'b1);
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd2, 2'b01, 5'd3, 1'b1, 1'b1);
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         ins(1'b1, 5'd0, 5'd3, 2'b01, 5'd4, 1'b0, 1'b0);
         #1;
         if (out === HAZ) stalls++;
         else break;
      end
      checks++;
      if (stalls !== LD) begin
         failures++;
         $display("FAIL bb_rewrite_stalls got=%0d exp=%0d", stalls, LD);
      end
      idle(4);
   endtask

   task automatic test_reset_mid_stall;
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1);
      @(negedge CLK);
      ins(1'b1, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== HAZ) begin
         failures++;
         $display("FAIL rm_stall got=%b exp=%b", out, HAZ);
      end
      @(negedge CLK);
      #2;
      nRST = 1'b0;
      ins(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL rm_idle got=%b exp=%b", out, NORM);
      end
      @(negedge CLK);
      nRST = 1'b1;
      ins(1'b1, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (out !== NORM) begin
         failures++;
         $display("FAIL rm_cleared got=%b exp=%b", out, NORM);
      end
      idle(2);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      nRST     = 1'b0;
      test_reset();
      test_load_use();
      test_mem_wait();
      test_flush();
      test_fetch_miss();
      test_unused_operand();
      test_self_dep();
      test_back_to_back();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
